price_feeder: RTL and testbench
===============================

Name: price_feeder

Overview:
Streams stock-price samples out of the on-chip SRAM window into the averaging datapath. It drives the SRAM read port and produces the stock_price/data_ready sample stream that the averager consumes. It reads an address range (inclusive, wrapping) once or in a loop, one sample per paced period.

Parameters:
ADDR_W, 5, SRAM address width; wraps modulo 2**ADDR_W.
DATA_W, 32, sample width.
RD_LAT, 1, SRAM read latency in cycles (read_data valid RD_LAT cycles after read_enable/address presented); legal 1..3.
GAP_CYCLES, 2, idle cycles inserted after each emitted sample; 0 legal.

Ports:
clk  in  1  system clock, rising edge.
n_rst  in  1  synchronous active-low reset.
start  in  1  begin a run; sampled only in IDLE.
abort  in  1  stop run at next edge; priority over all but reset.
loop  in  1  latched at start; 1 = restart at start_address after last_address.
start_address  in  ADDR_W  first address, latched at start.
last_address  in  ADDR_W  final address (inclusive), latched at start.
sram_read_enable  out  1  SRAM read strobe.
sram_address  out  ADDR_W  SRAM read address.
sram_read_data  in  DATA_W  SRAM read data.
stock_price  out  DATA_W  current sample; held between emits.
data_ready  out  1  one-cycle pulse; stock_price valid that cycle.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse at end of a non-loop run or abort.
sample_count  out  ADDR_W+1  samples emitted in current run (non-loop), saturates at 2**ADDR_W.

Behaviour:
- Reset (n_rst=0 at edge): state IDLE; all outputs 0; latched addresses/loop 0; counters 0.
- All outputs registered; no combinational in->out paths.
- States: IDLE, READ, WAIT, EMIT, GAP, DONE.
- IDLE: start=1 -> latch addresses/loop, cur_addr=start_address, sample_count=0, -> READ.
- READ: sram_read_enable=1, sram_address=cur_addr; -> WAIT.
- WAIT: read_enable and address held for RD_LAT cycles total (counter); on final cycle stock_price <= sram_read_data -> EMIT.
- EMIT: data_ready=1 for exactly this cycle; sample_count++ (saturating); read_enable=0. If cur_addr==last_address: loop ? (cur_addr=start_address, sample_count=0, -> GAP) : -> DONE; else cur_addr=cur_addr+1 mod 2**ADDR_W, -> GAP (or READ if GAP_CYCLES=0).
- GAP: hold GAP_CYCLES cycles, then -> READ.
- DONE: done=1 for one cycle, busy=0 -> IDLE.
- Latency: start sampled at edge E0 -> first data_ready in cycle E0+1+RD_LAT+1. Period between data_ready pulses = 2+RD_LAT+GAP_CYCLES cycles.
- Range: samples per run = ((last-start) mod 2**ADDR_W)+1; start==last gives 1 sample; last<start wraps through 31->0.
- start while busy: ignored. start and abort same edge in IDLE: abort wins, stays IDLE, no done.
- abort while busy: next state DONE (done pulses), read_enable=0 immediately, no data_ready for in-flight read; stock_price keeps last emitted value.
- Reset mid-run: immediate return to reset values regardless of state.
- Input address changes after start: no effect on run.

Decomposition:
- Package price_feed_pkg: ADDR_W/DATA_W defaults, feeder_state_t enum (IDLE, READ, WAIT, EMIT, GAP, DONE).
- No sub-module; single FSM plus address, latency and gap counters.

Test Plan:
- SRAM preloaded addr k = 100+k; start, start=2, last=5, loop=0, RD_LAT=1, GAP=2 -> data_ready ×4, stock_price 102,103,104,105, pulses 5 cycles apart, first in cycle E0+3, done one cycle after last EMIT, sample_count=4.
- Wrap: start=30, last=1 -> prices 130,131,100,101; sample_count=4; sram_address sequence 30,31,0,1.
- Single: start=last=7 -> one data_ready with 107, then done; GAP=0, RD_LAT=3 -> pulse in cycle E0+5.
- Loop: start=0, last=2, loop=1 -> 100,101,102,100,101,... no done; abort mid-WAIT -> no further data_ready, done pulses next cycle, busy drops.
- start asserted while busy -> run unaffected; start+abort same edge in IDLE -> stays IDLE, no done.
- n_rst=0 during EMIT -> next cycle all outputs 0, state IDLE; new start works normally.

Source files
------------

// File: rtl/price_feeder_pkg.sv
// Shared types and default widths for the price feeder that streams SRAM
// samples into the averaging datapath.
package price_feed_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    EMIT = 3'd3,
    GAP  = 3'd4,
    DONE = 3'd5
  } feeder_state_t;

endpackage

// File: rtl/price_feeder_if.sv
// SRAM read port between the price feeder (master) and the sample SRAM (slave).
interface price_feeder_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);

  logic              sram_read_enable;
  logic [ADDR_W-1:0] sram_address;
  logic [DATA_W-1:0] sram_read_data;

  modport master (
    output sram_read_enable,
    output sram_address,
    input  sram_read_data
  );

  modport slave (
    input  sram_read_enable,
    input  sram_address,
    output sram_read_data
  );

endinterface

// File: rtl/price_feeder.sv
// Walks an inclusive, wrapping SRAM address range once or in a loop and emits
// one registered stock_price/data_ready sample per paced period.
module price_feeder
  import price_feed_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LAT     = 1,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              abort,
  input  logic              loop,
  input  logic [ADDR_W-1:0] start_address,
  input  logic [ADDR_W-1:0] last_address,
  price_feeder_if.master    sram,
  output logic [DATA_W-1:0] stock_price,
  output logic              data_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   sample_count
);

  localparam int                GAP_W     = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [1:0]        LAT_LAST  = 2'(RD_LAT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  feeder_state_t     state_q, state_d;
  logic [ADDR_W-1:0] start_addr_q, start_addr_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic              loop_q, loop_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [1:0]        lat_cnt_q, lat_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;

  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] price_q, price_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W:0]   count_q, count_d;

  logic at_last;
  logic start_run;

  assign at_last   = (cur_addr_q == last_addr_q);
  assign start_run = (state_q == IDLE) && (state_d == READ);

  // NOTE: every always_comb assigns defaults first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start && !abort) state_d = READ;
      READ: state_d = WAIT;
      WAIT: if (lat_cnt_q == LAT_LAST) state_d = EMIT;
      EMIT: begin
        if (at_last && !loop_q) state_d = DONE;
        else                    state_d = (GAP_CYCLES == 0) ? READ : GAP;
      end
      GAP:  if (gap_cnt_q == GAP_LAST) state_d = READ;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort ends any active run through DONE so the consumer sees a done pulse.
    if (abort && (state_q != IDLE) && (state_q != DONE)) state_d = DONE;
  end

  always_comb begin
    start_addr_d = start_addr_q;
    last_addr_d  = last_addr_q;
    loop_d       = loop_q;
    cur_addr_d   = cur_addr_q;
    lat_cnt_d    = '0;
    gap_cnt_d    = '0;
    if (start_run) begin
      start_addr_d = start_address;
      last_addr_d  = last_address;
      loop_d       = loop;
      cur_addr_d   = start_address;
    end
    if (state_q == WAIT) lat_cnt_d = lat_cnt_q + 2'd1;
    if (state_q == GAP)  gap_cnt_d = gap_cnt_q + GAP_W'(1);
    if (state_q == EMIT) cur_addr_d = at_last ? start_addr_q : cur_addr_q + ADDR_W'(1);
  end

  // Outputs are derived from the next state so they are registered yet line up
  // with the state they describe.
  always_comb begin
    rd_en_d = (state_d == READ) || (state_d == WAIT);
    addr_d  = (state_d == READ) ? cur_addr_d : addr_q;
    ready_d = (state_d == EMIT);
    done_d  = (state_d == DONE);
    busy_d  = (state_d != IDLE) && (state_d != DONE);
    price_d = ((state_q == WAIT) && (state_d == EMIT)) ? sram.sram_read_data : price_q;
    count_d = count_q;
    if (start_run) begin
      count_d = '0;
    end else if (state_d == EMIT) begin
      count_d = (count_q == COUNT_MAX) ? count_q : count_q + 1'b1;
    end else if ((state_q == EMIT) && at_last && (state_d != DONE)) begin
      count_d = '0;
    end
  end

  // NOTE: reset is sampled on the clock edge only; n_rst is not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      start_addr_q <= '0;
      last_addr_q  <= '0;
      loop_q       <= 1'b0;
      cur_addr_q   <= '0;
      lat_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      rd_en_q      <= 1'b0;
      addr_q       <= '0;
      price_q      <= '0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      count_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      start_addr_q <= start_addr_d;
      last_addr_q  <= last_addr_d;
      loop_q       <= loop_d;
      cur_addr_q   <= cur_addr_d;
      lat_cnt_q    <= lat_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      rd_en_q      <= rd_en_d;
      addr_q       <= addr_d;
      price_q      <= price_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      count_q      <= count_d;
    end
  end

  assign sram.sram_read_enable = rd_en_q;
  assign sram.sram_address     = addr_q;
  assign stock_price           = price_q;
  assign data_ready            = ready_q;
  assign busy                  = busy_q;
  assign done                  = done_q;
  assign sample_count          = count_q;

endmodule

// File: tb/tb_price_feeder.sv
// Self-checking bench: two feeders (RD_LAT=1/GAP=2 and RD_LAT=3/GAP=0) reading
// an SRAM model that holds 100+k at address k.
module tb_price_feeder;
  import price_feed_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int LAT_A = 1;
  localparam int GAP_A = 2;
  localparam int LAT_B = 3;
  localparam int GAP_B = 0;
  localparam int PER_A = 2 + LAT_A + GAP_A;
  localparam int PER_B = 2 + LAT_B + GAP_B;

  typedef struct {
    logic [AW-1:0] sa;
    logic [AW-1:0] la;
    bit            poke;
    int            exp_n;
  } vec_t;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          start_a = 1'b0, start_b = 1'b0;
  logic          abort_a = 1'b0, abort_b = 1'b0;
  logic          loop_in = 1'b0;
  logic [AW-1:0] sa = '0, la = '0;

  logic [DW-1:0] stock_price_a, stock_price_b;
  logic          data_ready_a, data_ready_b, busy_a, busy_b, done_a, done_b;
  logic [AW:0]   sample_count_a, sample_count_b;

  int tests = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  price_feeder_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  price_feeder_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

  price_feeder #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT_A), .GAP_CYCLES(GAP_A)) dut_a (
    .clk(clk), .n_rst(n_rst), .start(start_a), .abort(abort_a), .loop(loop_in),
    .start_address(sa), .last_address(la), .sram(bus_a.master),
    .stock_price(stock_price_a), .data_ready(data_ready_a), .busy(busy_a),
    .done(done_a), .sample_count(sample_count_a)
  );

  price_feeder #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT_B), .GAP_CYCLES(GAP_B)) dut_b (
    .clk(clk), .n_rst(n_rst), .start(start_b), .abort(abort_b), .loop(loop_in),
    .start_address(sa), .last_address(la), .sram(bus_b.master),
    .stock_price(stock_price_b), .data_ready(data_ready_b), .busy(busy_b),
    .done(done_b), .sample_count(sample_count_b)
  );

  // SRAM models: data appears RD_LAT edges after the enabled address; a junk
  // word is returned for cycles without read_enable.
  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    return DW'(100) + DW'(a);
  endfunction

  logic [DW-1:0] pipe_a;
  logic [DW-1:0] pipe_b [3];
  always @(posedge clk) begin
    pipe_a    <= bus_a.sram_read_enable ? word(bus_a.sram_address) : 32'hDEADBEEF;
    pipe_b[0] <= bus_b.sram_read_enable ? word(bus_b.sram_address) : 32'hDEADBEEF;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign bus_a.sram_read_data = pipe_a;
  assign bus_b.sram_read_data = pipe_b[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard for dut_a: expected prices/addresses pushed by the stimulus.
  int   exp_price_q[$];
  int   exp_addr_q[$];
  int   dr_cnt_a = 0;
  int   first_dr_cyc_a = 0;
  int   last_dr_cyc_a = 0;
  logic done_seen_a = 1'b0;
  logic rd_prev_a = 1'b0;
  logic busy_prev_a = 1'b0;

  always @(negedge clk) begin
    if (!n_rst) begin
      rd_prev_a   = 1'b0;
      busy_prev_a = 1'b0;
    end else begin
      if (busy_a && !busy_prev_a) begin
        dr_cnt_a    = 0;
        done_seen_a = 1'b0;
      end
      busy_prev_a = busy_a;
      if (bus_a.sram_read_enable && !rd_prev_a) begin
        check("read_expected", 64'(exp_addr_q.size() > 0), 1);
        if (exp_addr_q.size() > 0) check("sram_address", bus_a.sram_address, exp_addr_q.pop_front());
      end
      rd_prev_a = bus_a.sram_read_enable;
      if (data_ready_a) begin
        dr_cnt_a++;
        if (dr_cnt_a == 1) first_dr_cyc_a = cyc;
        else check("pulse_period", cyc - last_dr_cyc_a, PER_A);
        last_dr_cyc_a = cyc;
        check("pulse_expected", 64'(exp_price_q.size() > 0), 1);
        if (exp_price_q.size() > 0) check("stock_price", stock_price_a, exp_price_q.pop_front());
      end
      if (done_a) done_seen_a = 1'b1;
    end
  end

  // One non-loop run on dut_a; inputs are scrambled after start to show they are latched.
  task automatic run_a(input vec_t v);
    int e0;
    for (int i = 0; i < v.exp_n; i++) begin
      exp_addr_q.push_back((int'(v.sa) + i) % 32);
      exp_price_q.push_back(100 + (int'(v.sa) + i) % 32);
    end
    @(negedge clk); #1;
    sa = v.sa; la = v.la; loop_in = 1'b0; start_a = 1'b1;
    e0 = cyc + 1;
    @(negedge clk); #1;
    start_a = 1'b0; sa = ~v.sa; la = ~v.la;
    if (v.poke) begin
      for (int c = 0; c < 50 && dr_cnt_a == 0; c++) begin @(negedge clk); #1; end
      start_a = 1'b1; sa = 5'd20; la = 5'd25;
      @(negedge clk); #1;
      start_a = 1'b0;
    end
    for (int c = 0; c < 400; c++) begin
      if (done_a) break;
      @(negedge clk); #1;
    end
    check("done_seen", done_a, 1);
    check("done_after_last_emit", cyc - last_dr_cyc_a, 1);
    // data_ready is high in the cycle ending at edge E0+RD_LAT+2.
    check("first_latency", first_dr_cyc_a - e0, LAT_A + 1);
    check("pulse_count", dr_cnt_a, v.exp_n);
    check("sample_count", sample_count_a, v.exp_n);
    check("busy_in_done", busy_a, 0);
    check("prices_drained", exp_price_q.size(), 0);
    @(negedge clk); #1;
    check("done_one_cycle", done_a, 0);
  endtask

  // One non-loop run on dut_b, checked inline.
  task automatic run_b(input logic [AW-1:0] s, input logic [AW-1:0] l, input int n);
    int e0, got, last;
    got = 0; last = 0;
    @(negedge clk); #1;
    sa = s; la = l; loop_in = 1'b0; start_b = 1'b1;
    e0 = cyc + 1;
    @(negedge clk); #1;
    start_b = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); #1;
      if (data_ready_b) begin
        if (got == 0) check("b_first_latency", cyc - e0, LAT_B + 1);
        else check("b_pulse_period", cyc - last, PER_B);
        check("b_stock_price", stock_price_b, 100 + (int'(s) + got) % 32);
        got++;
        last = cyc;
      end
      if (done_b) break;
    end
    check("b_done_seen", done_b, 1);
    check("b_done_after_last_emit", cyc - last, 1);
    check("b_pulse_count", got, n);
    check("b_sample_count", sample_count_b, n);
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{5'd2,  5'd5,  1'b1, 4};
    vecs[1] = '{5'd30, 5'd1,  1'b0, 4};
    vecs[2] = '{5'd7,  5'd7,  1'b0, 1};
    vecs[3] = '{5'd31, 5'd31, 1'b0, 1};
    vecs[4] = '{5'd0,  5'd31, 1'b0, 32};

    repeat (3) @(negedge clk);
    #1;
    check("rst_read_enable", bus_a.sram_read_enable, 0);
    check("rst_address", bus_a.sram_address, 0);
    check("rst_price", stock_price_a, 0);
    check("rst_ready", data_ready_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_count", sample_count_a, 0);
    check("rst_b_busy", busy_b, 0);
    n_rst = 1'b1;

    foreach (vecs[i]) run_a(vecs[i]);

    // start and abort together in IDLE: nothing happens.
    @(negedge clk); #1;
    start_a = 1'b1; abort_a = 1'b1;
    @(negedge clk); #1;
    start_a = 1'b0; abort_a = 1'b0;
    check("start_abort_busy", busy_a, 0);
    check("start_abort_read", bus_a.sram_read_enable, 0);
    check("start_abort_done", done_a, 0);
    @(negedge clk); #1;
    check("start_abort_done_later", done_a, 0);

    // Loop run 0..2, then abort while a read is in WAIT.
    begin
      int   loop_prices [5];
      logic prev;
      loop_prices = '{100, 101, 102, 100, 101};
      foreach (loop_prices[i]) exp_price_q.push_back(loop_prices[i]);
      for (int i = 0; i < 6; i++) exp_addr_q.push_back(i % 3);
      @(negedge clk); #1;
      sa = 5'd0; la = 5'd2; loop_in = 1'b1; start_a = 1'b1;
      @(negedge clk); #1;
      start_a = 1'b0; loop_in = 1'b0;
      for (int c = 0; c < 100; c++) begin
        if (dr_cnt_a >= 5) break;
        @(negedge clk); #1;
      end
      check("loop_pulses", dr_cnt_a, 5);
      check("loop_count_restart", sample_count_a, 2);
      check("loop_no_done", done_seen_a, 0);
      prev = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk); #1;
        if (bus_a.sram_read_enable && prev) break;
        prev = bus_a.sram_read_enable;
      end
      abort_a = 1'b1;
      @(negedge clk); #1;
      abort_a = 1'b0;
      check("abort_done", done_a, 1);
      check("abort_busy", busy_a, 0);
      check("abort_ready", data_ready_a, 0);
      check("abort_read_enable", bus_a.sram_read_enable, 0);
      check("abort_price_held", stock_price_a, 101);
      repeat (3) @(negedge clk);
      #1;
      check("abort_no_more_pulses", dr_cnt_a, 5);
      check("abort_done_once", done_a, 0);
      check("abort_addr_drained", exp_addr_q.size(), 0);
    end

    // Reset while in EMIT, then a normal run.
    exp_price_q.push_back(102);
    exp_addr_q.push_back(2);
    @(negedge clk); #1;
    sa = 5'd2; la = 5'd5; start_a = 1'b1;
    @(negedge clk); #1;
    start_a = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (data_ready_a) break;
      @(negedge clk); #1;
    end
    check("pre_reset_emit", data_ready_a, 1);
    n_rst = 1'b0;
    @(negedge clk); #1;
    check("mid_rst_read_enable", bus_a.sram_read_enable, 0);
    check("mid_rst_address", bus_a.sram_address, 0);
    check("mid_rst_price", stock_price_a, 0);
    check("mid_rst_ready", data_ready_a, 0);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_done", done_a, 0);
    check("mid_rst_count", sample_count_a, 0);
    check("mid_rst_queue", exp_price_q.size(), 0);
    n_rst = 1'b1;
    run_a('{5'd3, 5'd4, 1'b0, 2});

    // Slow SRAM, no gap.
    run_b(5'd7, 5'd7, 1);
    run_b(5'd6, 5'd8, 3);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (tests %0d, failed %0d)", tests, errors);
    $fatal(1);
  end

endmodule
